// File: rtl/avs_mm_crc_engine.sv
// Avalon-MM slave CRC accelerator with configurable width, polynomial, init,
// xorout, reflection and bus width. Enabled bytes of a DATA write are folded
// into the CRC one per clock, lowest lane first, while the master is stalled
// on any access that would observe or disturb the in-flight result.
module avs_mm_crc_engine #(
   parameter int          DATA_W  = 32,
   parameter int          CRC_W   = 32,
   parameter logic [31:0] POLY    = 32'h04C11DB7,
   parameter logic [31:0] INIT    = 32'hFFFFFFFF,
   parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
   parameter int          REFLECT = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          avs_address,
   input  logic                avs_read,
   output logic [DATA_W-1:0]   avs_readdata,
   input  logic                avs_write,
   input  logic [DATA_W-1:0]   avs_writedata,
   input  logic [DATA_W/8-1:0] avs_byteenable,
   output logic                avs_waitrequest
);

   localparam int NB = DATA_W / 8;

   localparam logic [7:0] ADDR_DATA   = 8'h00;
   localparam logic [7:0] ADDR_CTRL   = 8'h01;
   localparam logic [7:0] ADDR_STATUS = 8'h02;
   localparam logic [7:0] ADDR_RAW    = 8'h03;
   localparam logic [7:0] ADDR_COUNT  = 8'h04;

   function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] v);
      logic [CRC_W-1:0] r;
      r = '0;
      for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
      return r;
   endfunction

   localparam logic [CRC_W-1:0] POLY_N   = POLY[CRC_W-1:0];
   localparam logic [CRC_W-1:0] POLY_R   = bit_rev(POLY[CRC_W-1:0]);
   localparam logic [CRC_W-1:0] INIT_N   = INIT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] XOROUT_N = XOROUT[CRC_W-1:0];

   // One byte of CRC as eight unrolled bit-serial steps.
   function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c_in,
                                                 input logic [7:0] b);
      logic [CRC_W-1:0] c;
      c = c_in;
      if (REFLECT != 0) begin
         c[7:0] = c[7:0] ^ b;
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
      end else begin
         c[CRC_W-1 -: 8] = c[CRC_W-1 -: 8] ^ b;
         for (int k = 0; k < 8; k++) c = c[CRC_W-1] ? ((c << 1) ^ POLY_N) : (c << 1);
      end
      return c;
   endfunction

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state;
   logic [CRC_W-1:0]   crc;
   logic [31:0]        count;
   logic [NB-1:0]      mask;
   logic [DATA_W-1:0]  data;

   logic               busy;
   logic               stall_addr;
   logic               wr_acc;
   logic               rd_acc;
   logic [7:0]         lane_byte;
   logic [NB-1:0]      next_mask;
   logic [63:0]        rd_word;

   assign busy       = (state == BUSY);
   assign stall_addr = (avs_address == ADDR_DATA) || (avs_address == ADDR_CTRL) ||
                       (avs_address == ADDR_RAW);

   // Stall only accesses that touch the CRC while bytes are still in flight;
   // reset always releases the bus.
   assign avs_waitrequest = reset && busy && (avs_read || avs_write) && stall_addr;
   assign wr_acc          = reset && avs_write && !avs_waitrequest;
   assign rd_acc          = reset && avs_read && !avs_write && !avs_waitrequest;

   // Pick the lowest pending lane and drop it from the remaining mask.
   always_comb begin
      lane_byte = '0;
      for (int i = NB - 1; i >= 0; i--) begin
         if (mask[i]) lane_byte = data[i*8 +: 8];
      end
      next_mask = mask & (mask - NB'(1));
   end

   // Register readback mux; unused addresses and unaccepted cycles return 0.
   always_comb begin
      rd_word = '0;
      case (avs_address)
         ADDR_DATA:   rd_word = 64'(crc ^ XOROUT_N);
         ADDR_STATUS: rd_word = 64'(busy);
         ADDR_RAW:    rd_word = 64'(crc);
         ADDR_COUNT:  rd_word = 64'(count);
         default:     rd_word = '0;
      endcase
      avs_readdata = rd_acc ? rd_word[DATA_W-1:0] : '0;
   end

   // Control FSM: latch a DATA word in IDLE, then fold one byte per clock.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         crc   <= INIT_N;
         count <= '0;
         mask  <= '0;
         data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_acc) begin
                  if (avs_address == ADDR_DATA && avs_byteenable != '0) begin
                     data  <= avs_writedata;
                     mask  <= avs_byteenable;
                     state <= BUSY;
                  end else if (avs_address == ADDR_CTRL && avs_writedata[0]) begin
                     crc   <= INIT_N;
                     count <= '0;
                  end
               end
            end
            BUSY: begin
               crc   <= crc_byte(crc, lane_byte);
               count <= count + 32'd1;
               mask  <= next_mask;
               if (next_mask == '0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avs_mm_crc_engine.sv
// Directed bench for avs_mm_crc_engine with default CRC-32 parameters.
// Expected read values go into a scoreboard queue when a read is issued; a
// monitor pops and compares whenever the DUT accepts a read.
module tb_avs_mm_crc_engine;

   logic        clk;
   logic        reset;
   logic [7:0]  avs_address;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic        avs_waitrequest;

   int vectors;
   int miscompares;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];

   avs_mm_crc_engine dut (
      .clk             (clk),
      .reset           (reset),
      .avs_address     (avs_address),
      .avs_read        (avs_read),
      .avs_readdata    (avs_readdata),
      .avs_write       (avs_write),
      .avs_writedata   (avs_writedata),
      .avs_byteenable  (avs_byteenable),
      .avs_waitrequest (avs_waitrequest)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every accepted read is compared against the oldest expectation.
   always @(negedge clk) begin
      if (reset && avs_read && !avs_write && !avs_waitrequest) begin
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_read: got 0x%08h, wanted no read", avs_readdata);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (avs_readdata !== e.exp) begin
               miscompares++;
               $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", e.name, avs_readdata, e.exp);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one bus access and hold it until the DUT stops stalling.
   task automatic applyStimulus(input logic [7:0] addr, input logic rd, input logic wr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output int stalls, output logic [31:0] rdata);
      bit done;
      done           = 0;
      stalls         = 0;
      rdata          = '0;
      avs_address    = addr;
      avs_read       = rd;
      avs_write      = wr;
      avs_writedata  = wdata;
      avs_byteenable = be;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (avs_waitrequest) stalls++;
         else begin
            rdata = avs_readdata;
            done  = 1;
         end
         @(posedge clk);
         #1;
      end
      avs_read  = 1'b0;
      avs_write = 1'b0;
      if (!done) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL timeout: got stalled 40 cycles, wanted completion at addr 0x%02h", addr);
         if (rd && !wr && sb_q.size() > 0) void'(sb_q.pop_back());
      end
   endtask

   task automatic readExpect(input logic [7:0] addr, input logic [31:0] exp,
                             input string name, input int exp_stalls);
      int          s;
      logic [31:0] r;
      exp_t        e;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
      applyStimulus(addr, 1'b1, 1'b0, '0, '0, s, r);
      if (exp_stalls >= 0) checkOutput({name, "_stalls"}, 32'(s), 32'(exp_stalls));
   endtask

   task automatic writeReg(input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output int stalls);
      logic [31:0] r;
      applyStimulus(addr, 1'b0, 1'b1, wdata, be, stalls, r);
   endtask

   initial begin
      int          s;
      logic [31:0] r;
      vectors        = 0;
      miscompares    = 0;
      reset          = 1'b0;
      avs_address    = '0;
      avs_read       = 1'b0;
      avs_write      = 1'b0;
      avs_writedata  = '0;
      avs_byteenable = '0;

      // Reset held: bus must read 0 and never stall.
      idle(3);
      avs_address = 8'h03;
      avs_read    = 1'b1;
      @(negedge clk);
      checkOutput("rst_readdata", avs_readdata, 32'h0);
      checkOutput("rst_wait", 32'(avs_waitrequest), 32'h0);
      @(posedge clk);
      #1;
      avs_read = 1'b0;
      reset    = 1'b1;
      idle(1);

      // Register values after reset.
      readExpect(8'h00, 32'h00000000, "rst_data", 0);
      readExpect(8'h03, 32'hFFFFFFFF, "rst_raw", 0);
      readExpect(8'h02, 32'h00000000, "rst_status", 0);
      readExpect(8'h04, 32'h00000000, "rst_count", 0);

      // Single byte 0x01: one busy cycle.
      writeReg(8'h00, 32'h00000001, 4'b0001, s);
      readExpect(8'h02, 32'h1, "one_busy", 0);
      readExpect(8'h02, 32'h0, "one_idle", 0);
      readExpect(8'h00, 32'hA505DF1B, "one_data", 0);
      readExpect(8'h04, 32'd1, "one_count", 0);

      // "123456789" over three writes, second one back-to-back.
      writeReg(8'h01, 32'h1, 4'b1111, s);
      writeReg(8'h00, 32'h34333231, 4'b1111, s);
      writeReg(8'h00, 32'h38373635, 4'b1111, s);
      checkOutput("b2b_stalls", 32'(s), 32'd4);
      writeReg(8'h00, 32'h00000039, 4'b0001, s);
      checkOutput("b2b_third_stalls", 32'(s), 32'd4);
      readExpect(8'h00, 32'hCBF43926, "check_data", 1);
      readExpect(8'h04, 32'd9, "check_count", 0);

      // CLEAR then a single zero byte.
      writeReg(8'h01, 32'h1, 4'b1111, s);
      readExpect(8'h00, 32'h00000000, "clr_data", 0);
      readExpect(8'h04, 32'h00000000, "clr_count", 0);
      writeReg(8'h00, 32'h00000000, 4'b0001, s);
      readExpect(8'h00, 32'hD202EF8D, "zero_data", 1);

      // Empty byteenable does nothing; unmapped address never stalls.
      writeReg(8'h00, 32'h12345678, 4'b0000, s);
      readExpect(8'h02, 32'h0, "be0_status", 0);
      readExpect(8'h03, 32'h2DFD1072, "be0_raw", 0);
      readExpect(8'h10, 32'h0, "unmapped", 0);

      // Read and write together behaves as a write and returns 0.
      applyStimulus(8'h02, 1'b1, 1'b1, 32'h0, 4'b1111, s, r);
      checkOutput("rdwr_readdata", r, 32'h0);

      // STATUS/COUNT readable mid-busy; CLEAR stalls until done.
      writeReg(8'h01, 32'h1, 4'b1111, s);
      writeReg(8'h00, 32'h11223344, 4'b1111, s);
      readExpect(8'h02, 32'h1, "mid_status", 0);
      readExpect(8'h04, 32'd1, "mid_count", 0);
      writeReg(8'h01, 32'h1, 4'b1111, s);
      checkOutput("clr_busy_stalls", 32'(s), 32'd2);
      readExpect(8'h04, 32'd0, "clr_busy_count", 0);
      readExpect(8'h00, 32'h0, "clr_busy_data", 0);

      // Reset on the second busy cycle discards the word.
      writeReg(8'h00, 32'hAABBCCDD, 4'b1111, s);
      idle(1);
      reset       = 1'b0;
      avs_address = 8'h00;
      avs_read    = 1'b1;
      @(negedge clk);
      checkOutput("midrst_wait", 32'(avs_waitrequest), 32'h0);
      checkOutput("midrst_readdata", avs_readdata, 32'h0);
      @(posedge clk);
      #1;
      avs_read = 1'b0;
      reset    = 1'b1;
      readExpect(8'h02, 32'h0, "midrst_status", 0);
      readExpect(8'h03, 32'hFFFFFFFF, "midrst_raw", 0);
      readExpect(8'h04, 32'h0, "midrst_count", 0);

      idle(2);
      if (sb_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, wanted 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
